// File: rtl/fetch_stall_unit.sv
// Fetch unit: issues imem requests, buffers responses in a small queue and feeds decode.
// Optional `JUMP_PREDECODE_EN`: re-steers the PC on a fetched j instruction.
module fetch_stall_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_rvalid,
  input  logic [31:0]              imem_rdata,
  output logic                     if_valid,
  output logic [31:0]              if_instr,
  output logic [31:0]              if_pc,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW+1:0] CreditMax = (AW+2)'(DEPTH);

  typedef enum logic [1:0] {StReset, StFetch, StHold, StRedirect} state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          inflight_q, inflight_d;
  logic          kill_q, kill_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          if_valid_q, if_valid_d;
  logic [31:0]   if_instr_q, if_instr_d;
  logic [31:0]   if_pc_q, if_pc_d;

  logic [31:0]   mem_instr_q [DEPTH];
  logic [31:0]   mem_pc_q    [DEPTH];

  logic          resp_ok;
  logic          jump_hit;
  logic          push;
  logic          pop;
  logic          bypass;
  logic [AW+1:0] credit;

  assign resp_ok = imem_rvalid && inflight_q && !kill_q;
  assign credit  = {1'b0, count_q} + (AW+2)'(inflight_q);

`ifdef JUMP_PREDECODE_EN
  logic [31:0] jump_target;
  assign jump_hit    = resp_ok && (imem_rdata[31:26] == 6'b000010);
  assign jump_target = {4'((req_pc_q + 32'd4) >> 28), imem_rdata[25:0], 2'b00};
`else
  assign jump_hit = 1'b0;
`endif

  always_comb begin
    imem_req  = ((state_q == StFetch) || (state_q == StHold)) && (credit < CreditMax);
    imem_addr = pc_q;
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = StRedirect;
    end else begin
      unique case (state_q)
        StReset:    state_d = StFetch;
        StFetch:    state_d = stall ? StFetch : StHold;
        StHold:     state_d = stall ? StFetch : StHold;
        StRedirect: state_d = stall ? StFetch : StHold;
        default:    state_d = StReset;
      endcase
    end
  end

  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = imem_req | (inflight_q & ~imem_rvalid);
    // Only one request can be outstanding, so the kill tag follows the request issued now.
    kill_d     = imem_req & (redirect_valid | jump_hit);
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    if_valid_d = 1'b0;
    if_instr_d = 32'h0;
    if_pc_d    = if_pc_q;
    push       = 1'b0;
    pop        = 1'b0;
    bypass     = 1'b0;

    if (imem_req) begin
      pc_d     = pc_q + 32'd4;
      req_pc_d = pc_q;
    end

    if (redirect_valid) begin
      pc_d    = redirect_pc;
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
`ifdef JUMP_PREDECODE_EN
      if (jump_hit) begin
        pc_d = jump_target;
      end
`endif
      if (stall && (state_q != StRedirect)) begin
        if (count_q != '0) begin
          pop = 1'b1;
        end else if (resp_ok) begin
          bypass = 1'b1;
        end
      end
      push = resp_ok && !bypass;

      if (pop) begin
        if_valid_d = 1'b1;
        if_instr_d = mem_instr_q[rptr_q];
        if_pc_d    = mem_pc_q[rptr_q];
        rptr_d     = rptr_q + AW'(1);
      end else if (bypass) begin
        if_valid_d = 1'b1;
        if_instr_d = imem_rdata;
        if_pc_d    = req_pc_q;
      end

      if (push) begin
        wptr_d = wptr_q + AW'(1);
      end

      unique case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StReset;
      pc_q       <= PC_RESET;
      req_pc_q   <= 32'h0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      if_valid_q <= 1'b0;
      if_instr_q <= 32'h0;
      if_pc_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
    end
  end

  // Queue storage needs no reset; occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr_q[wptr_q] <= imem_rdata;
      mem_pc_q[wptr_q]    <= req_pc_q;
    end
  end

  assign if_valid = if_valid_q;
  assign if_instr = if_instr_q;
  assign if_pc    = if_pc_q;
  assign q_count  = count_q;

endmodule

// File: doc/fetch_stall_unit.md
Name: fetch_stall_unit

Overview:
- Fetch-side consumer of the pipeline stall/NOP control. Generates the instruction-memory PC and buffers fetched words in a small queue.
- Honours the active-low stall from hazard control (stall=1 run, stall=0 hold/squash) and delivers one instruction per cycle to decode.
- Re-steers the PC when the execute stage resolves a branch or jump.
- Sits between instruction memory and the IF/ID pipeline register.

Parameters:
- DEPTH, 4, queue entries; power of 2, minimum 2.
- PC_RESET, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hazard control; 1 = run, 0 = hold queue and emit NOP.
- redirect_valid  in  1  branch/jump resolved as taken; single-cycle pulse.
- redirect_pc  in  32  target PC; sampled when redirect_valid=1.
- imem_req  out  1  fetch request this cycle.
- imem_addr  out  32  word address of the request.
- imem_rvalid  in  1  response valid; exactly 1 cycle after imem_req.
- imem_rdata  in  32  instruction word.
- if_valid  out  1  if_instr/if_pc are a real instruction.
- if_instr  out  32  instruction to decode; 32'b0 (NOP) when not valid.
- if_pc  out  32  PC of if_instr.
- q_count  out  $clog2(DEPTH)+1  current queue occupancy.

Behaviour:
- Reset (async assert, sync release): pc=PC_RESET, queue empty, inflight=0, imem_req=0, if_valid=0, if_instr=0, if_pc=0, q_count=0.
- State machine, registered:
  - RESET→FETCH on the first edge after release.
  - FETCH→HOLD when stall=0.
  - HOLD→FETCH when stall=1.
  - Any state→REDIRECT when redirect_valid=1.
  - REDIRECT→FETCH (or HOLD if stall=0) after exactly 1 cycle.
- Issue rule, combinational: imem_req=1 iff state∈{FETCH,HOLD} and q_count+inflight < DEPTH. imem_addr=pc. pc advances by 4 on each issue, wrapping modulo 2^32.
- Fetch continues during HOLD until the queue is full; it is not gated by stall.
- inflight: set on issue, cleared on response. At most 1 outstanding request.
- Response: when imem_rvalid=1 and not killed, push {pc_of_req, imem_rdata}. A push into a full queue cannot occur, because of the credit rule.
- Pop: when stall=1, queue non-empty and state≠REDIRECT, pop the head into if_instr/if_pc with if_valid=1 (registered, 1-cycle latency).
  - If the queue is empty and a response arrives the same cycle, bypass it straight into the output registers.
  - Otherwise the output becomes if_valid=0, if_instr=0; if_pc holds its value.
- stall=0: output registers load if_valid=0, if_instr=0 the next cycle. Queue contents and PC are held, apart from fill.
- Redirect:
  - Queue is flushed (q_count=0) and pc<=redirect_pc.
  - Any outstanding response is marked killed and dropped when it arrives.
  - Output shows a NOP the next cycle.
  - First request to redirect_pc is issued in the REDIRECT cycle+1.
  - redirect_valid outranks stall, pop and push in the same cycle.
- Simultaneous push+pop: occupancy unchanged. Pointers wrap modulo DEPTH.
- rst_n asserted mid-operation: immediately returns to reset values; any pending response is ignored.

Optional Feature:
- Macro JUMP_PREDECODE_EN.
- Defined:
  - Each accepted response is predecoded.
  - If opcode imem_rdata[31:26]==6'b000010 (j), pc <= {pc_of_req+4 [31:28], imem_rdata[25:0], 2'b00} the next cycle. The j word itself is still pushed.
  - Any request issued after the j is killed.
  - beq/bne still rely on redirect_valid.
  - An external redirect in the same cycle wins.
- Undefined: no predecode; j words are treated like any other instruction.

Test Plan:
- Reset release, stall=1, imem returns words W0..W3 for addrs 0,4,8,12 → if_pc 0,4,8,12 on consecutive cycles; first if_valid=1 at cycle 3 after release.
- stall=0 held 8 cycles after 2 instructions → if_instr=0, if_valid=0 throughout; imem_req stops when q_count=4; on stall=1, the next 4 outputs are the buffered PCs in order.
- redirect_valid=1, redirect_pc=32'h0000_0100, with q_count=3 and one inflight → q_count=0 next cycle, inflight word never appears; next imem_addr=0x100.
- redirect_valid and stall=0 in the same cycle → queue flushed, pc=redirect_pc, output NOP; fetch from redirect_pc proceeds and fills the queue while stalled.
- pc=32'hFFFF_FFFC issue → next imem_addr=0; rst_n pulsed low mid-fill → all outputs zero immediately, next fetch at PC_RESET.
- JUMP_PREDECODE_EN: word 32'h0800_0040 (j) fetched at pc 0x10 → next imem_addr=0x100, sequential 0x14 response dropped; without the macro → 0x14 is fetched and delivered.
